mul_div_unit: RTL and testbench

- Multi-cycle multiply/divide responder for the MIPS datapath; owns the HI/LO register pair.
- The combinational ALU issues single-cycle ops. The decode/control path acts as initiator and hands MULT/DIV/MTHI/MTLO requests to this block over a start/busy/done handshake.
- Radix-2 iterative engine: one bit per cycle; a full operation takes WIDTH cycles.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_step.sv | 37 +++
 rtl/mul_div_unit.sv | 172 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared op encoding, FSM state and datapath mode types for the HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MTHI  = 2'b10;
  localparam logic [1:0] OP_MTLO  = 2'b11;
  localparam int unsigned OP_SIGNED_BIT = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  typedef enum logic {
    MODE_MUL,
    MODE_DIV
  } mode_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide, purely combinational.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  mode_t            i_mode,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_shreg,
  input  logic [WIDTH-1:0] i_operand,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_shreg
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  always_comb begin
    // Multiply: {acc, shreg} is the product register, multiplier bits shift out of shreg[0].
    w_sum    = {1'b0, i_acc} + (i_shreg[0] ? {1'b0, i_operand} : '0);
    // Divide: acc is the partial remainder, dividend bits shift in from the top of shreg.
    w_rem_sh = {i_acc, i_shreg[WIDTH-1]};
    w_ge     = (w_rem_sh >= {1'b0, i_operand});
    w_diff   = w_rem_sh[WIDTH-1:0] - i_operand;

    if (i_mode == MODE_DIV) begin
      o_acc   = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
      o_shreg = {i_shreg[WIDTH-2:0], w_ge};
    end else begin
      o_acc   = w_sum[WIDTH:1];
      o_shreg = {w_sum[0], i_shreg[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/DIV engine owning HI/LO; one bit per cycle, start/busy/done handshake.
// Define SIGNED_MULDIV_EN to honour op[2] as the signed flag (magnitude run + sign fix-up).
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_rs_val,
  input  logic [WIDTH-1:0] i_rt_val,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned        COUNT_W  = $clog2(WIDTH) + 1;
  localparam logic [COUNT_W-1:0] CNT_LAST = COUNT_W'(WIDTH - 1);

  state_t             r_state;
  mode_t              r_mode;
  logic               r_busy;
  logic               r_done;
  logic               r_div_by_zero;
  logic               r_rt_zero;
  logic [COUNT_W-1:0] r_count;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_shreg;
  logic [WIDTH-1:0]   r_operand;

  logic [WIDTH-1:0]   w_rs_op;
  logic [WIDTH-1:0]   w_rt_op;
  logic [WIDTH-1:0]   w_step_acc;
  logic [WIDTH-1:0]   w_step_shreg;
  logic [WIDTH-1:0]   w_fin_hi;
  logic [WIDTH-1:0]   w_fin_lo;
  logic               w_op_div;

  assign w_op_div = (i_op[1:0] == OP_DIVU);

`ifdef SIGNED_MULDIV_EN
  logic             r_neg_res;
  logic             r_neg_rem;
  logic [WIDTH-1:0] r_rs_raw;
  logic             w_signed;
  logic             w_neg_res;
  logic             w_neg_rem;

  always_comb begin
    w_signed  = i_op[OP_SIGNED_BIT];
    w_rs_op   = (w_signed && i_rs_val[WIDTH-1]) ? -i_rs_val : i_rs_val;
    w_rt_op   = (w_signed && i_rt_val[WIDTH-1]) ? -i_rt_val : i_rt_val;
    w_neg_res = w_signed && (i_rs_val[WIDTH-1] ^ i_rt_val[WIDTH-1]);
    w_neg_rem = w_signed && i_rs_val[WIDTH-1];
  end

  // Sign fix-up is applied to the last iteration's output so FIN sees the final value.
  always_comb begin
    w_fin_hi = w_step_acc;
    w_fin_lo = w_step_shreg;
    if (r_mode == MODE_DIV) begin
      if (r_rt_zero) begin
        w_fin_hi = r_rs_raw;
      end else begin
        if (r_neg_res) w_fin_lo = -w_step_shreg;
        if (r_neg_rem) w_fin_hi = -w_step_acc;
      end
    end else if (r_neg_res) begin
      {w_fin_hi, w_fin_lo} = -{w_step_acc, w_step_shreg};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_rs_raw  <= '0;
    end else if (i_start && r_state != RUN && !i_op[1]) begin
      r_neg_res <= w_neg_res;
      r_neg_rem <= w_neg_rem;
      r_rs_raw  <= i_rs_val;
    end
  end
`else
  logic w_unused_op;

  assign w_unused_op = i_op[OP_SIGNED_BIT];
  assign w_rs_op     = i_rs_val;
  assign w_rt_op     = i_rt_val;
  assign w_fin_hi    = w_step_acc;
  assign w_fin_lo    = w_step_shreg;
`endif

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_mode   (r_mode),
    .i_acc    (r_acc),
    .i_shreg  (r_shreg),
    .i_operand(r_operand),
    .o_acc    (w_step_acc),
    .o_shreg  (w_step_shreg)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_mode        <= MODE_MUL;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_rt_zero     <= 1'b0;
      r_count       <= '0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_acc         <= '0;
      r_shreg       <= '0;
      r_operand     <= '0;
    end else begin
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
      case (r_state)
        RUN: begin
          r_acc   <= w_step_acc;
          r_shreg <= w_step_shreg;
          r_count <= r_count + COUNT_W'(1);
          if (r_count == CNT_LAST) begin
            r_state       <= FIN;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_div_by_zero <= (r_mode == MODE_DIV) && r_rt_zero;
            r_hi          <= w_fin_hi;
            r_lo          <= w_fin_lo;
          end
        end
        default: begin
          // IDLE and FIN both accept a new request; FIN otherwise falls back to IDLE.
          r_state <= IDLE;
          if (i_start) begin
            if (!i_op[1]) begin
              r_state   <= RUN;
              r_busy    <= 1'b1;
              r_count   <= '0;
              r_mode    <= w_op_div ? MODE_DIV : MODE_MUL;
              r_rt_zero <= (i_rt_val == '0);
              r_acc     <= '0;
              r_shreg   <= w_op_div ? w_rs_op : w_rt_op;
              r_operand <= w_op_div ? w_rt_op : w_rs_op;
            end else if (i_op[1:0] == OP_MTLO) begin
              r_lo <= i_rs_val;
            end else begin
              r_hi <= i_rs_val;
            end
          end
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_div_by_zero = r_div_by_zero;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, handshake corner cases and
// randomized ops against an arithmetic reference model (signed when SIGNED_MULDIV_EN is set).
module tb_mul_div_unit;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  rs;
  logic [W-1:0]  rt;
  logic          busy;
  logic          done;
  logic          dbz;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edbz;
  } vec_t;

  vec_t vecs[$];

  mul_div_unit #(
    .WIDTH(W)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_op         (op),
    .i_rs_val     (rs),
    .i_rt_val     (rt),
    .o_busy       (busy),
    .o_done       (done),
    .o_div_by_zero(dbz),
    .o_hi         (hi),
    .o_lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void ref_model(input logic [2:0] o, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] rhi,
                                    output logic [31:0] rlo, output logic rdbz);
    bit          s;
    logic [63:0] p;
    int          sa;
    int          sb;
`ifdef SIGNED_MULDIV_EN
    s = o[2];
`else
    s = 1'b0;
`endif
    sa   = a;
    sb   = b;
    rdbz = 1'b0;
    if (o[0] == 1'b0) begin
      if (s) p = 64'(longint'(sa) * longint'(sb));
      else   p = {32'b0, a} * {32'b0, b};
      {rhi, rlo} = p;
    end else if (b == 0) begin
      rlo  = '1;
      rhi  = a;
      rdbz = 1'b1;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        rlo = 32'h8000_0000;
        rhi = 32'h0;
      end else begin
        rlo = sa / sb;
        rhi = sa % sb;
      end
    end else begin
      rlo = a / b;
      rhi = a % b;
    end
  endfunction

  // Called and returns just after a negedge. Optionally injects a MULTU then an MTHI while busy.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edbz, input int inject, input bit settle);
    logic [31:0] hi0;
    logic [31:0] lo0;
    int          cnt;
    bit          stable;
    hi0   = hi;
    lo0   = lo;
    start = 1'b1;
    op    = o;
    rs    = a;
    rt    = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy_on_accept"}, 32'(busy), 32'd1);
    cnt    = 0;
    stable = 1'b1;
    while (!done && cnt < W + 8) begin
      if (busy !== 1'b1 || hi !== hi0 || lo !== lo0 || dbz !== 1'b0) stable = 1'b0;
      if (inject > 0 && cnt == inject) begin
        start = 1'b1;
        op    = 3'b000;
        rs    = 32'd9;
        rt    = 32'd9;
      end else if (inject > 0 && cnt == inject + 1) begin
        op = 3'b010;
        rs = 32'h55;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    check({name, "_latency"}, 32'(cnt), 32'(W));
    check({name, "_run_stable"}, 32'(stable), 32'd1);
    check({name, "_busy_in_fin"}, 32'(busy), 32'd0);
    check({name, "_hi"}, hi, ehi);
    check({name, "_lo"}, lo, elo);
    check({name, "_dbz"}, 32'(dbz), 32'(edbz));
    if (settle) begin
      @(posedge clk);
      @(negedge clk);
      check({name, "_done_one_cycle"}, 32'(done), 32'd0);
      check({name, "_dbz_cleared"}, 32'(dbz), 32'd0);
    end
  endtask

  task automatic do_mt(input string name, input bit is_lo, input logic [31:0] v);
    logic [31:0] other;
    other = is_lo ? hi : lo;
    start = 1'b1;
    op    = is_lo ? 3'b011 : 3'b010;
    rs    = v;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({name, "_value"}, is_lo ? lo : hi, v);
    check({name, "_other_kept"}, is_lo ? hi : lo, other);
    check({name, "_no_busy_done"}, {30'b0, busy, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edbz;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          ndone;

    vecs.push_back('{"multu_6x3", 3'b000, 32'd6, 32'd3, 32'd0, 32'd18, 1'b0});
    vecs.push_back('{"multu_max", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                     32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
    vecs.push_back('{"divu_10_4", 3'b001, 32'd10, 32'd4, 32'd2, 32'd2, 1'b0});
    vecs.push_back('{"divu_12_0", 3'b001, 32'd12, 32'd0, 32'd12, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{"divu_max_1", 3'b001, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0});
`ifdef SIGNED_MULDIV_EN
    vecs.push_back('{"div_s_m7_2", 3'b101, 32'hFFFF_FFF9, 32'd2,
                     32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{"div_s_ovf", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF,
                     32'h0, 32'h8000_0000, 1'b0});
    vecs.push_back('{"div_s_m12_0", 3'b101, 32'hFFFF_FFF4, 32'd0,
                     32'hFFFF_FFF4, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{"mult_s_m3_5", 3'b100, 32'hFFFF_FFFD, 32'd5,
                     32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0});
`else
    vecs.push_back('{"div_s_m7_2", 3'b101, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 1'b0});
    vecs.push_back('{"mult_s_m3_5", 3'b100, 32'hFFFF_FFFD, 32'd5, 32'd4, 32'hFFFF_FFF1, 1'b0});
`endif

    rst   = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    rs    = '0;
    rt    = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_dbz", 32'(dbz), 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].ehi, vecs[i].elo,
             vecs[i].edbz, 0, 1'b1);
    end

    // Requests while busy are dropped; then a request in the FIN cycle is taken back-to-back.
    run_op("divu_100_7_drop", 3'b001, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 5, 1'b0);
    run_op("b2b_multu_6x3", 3'b000, 32'd6, 32'd3, 32'd0, 32'd18, 1'b0, 0, 1'b1);

    // Reset mid-operation: outputs clear and no done ever appears.
    start = 1'b1;
    op    = 3'b000;
    rs    = 32'd123;
    rt    = 32'd456;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    ndone = 0;
    repeat (W + 5) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);

    do_mt("mtlo_abcd", 1'b1, 32'h0000_ABCD);
    do_mt("mthi_1234", 1'b0, 32'h1234_5678);

    // Reset and start on the same edge: reset wins.
    rst   = 1'b1;
    start = 1'b1;
    op    = 3'b011;
    rs    = 32'hDEAD;
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);
    check("rst_start_lo", lo, 32'd0);

    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'hFF;
      if (rop[1]) begin
        do_mt($sformatf("rnd%0d_mt", n), rop[0], ra);
      end else begin
        ref_model(rop, ra, rb, ehi, elo, edbz);
        run_op($sformatf("rnd%0d_op%0d", n, rop), rop, ra, rb, ehi, elo, edbz, 0, 1'b1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
